// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester, UART TX and status signals of the TX scheduler
interface uart_tx_sched_if;
  logic                i_req0_valid;
  logic [7:0]          i_req0_data;
  logic                i_req0_last;
  logic                o_req0_ready;
  logic                i_req1_valid;
  logic [7:0]          i_req1_data;
  logic                i_req1_last;
  logic                o_req1_ready;
  logic [7:0]          o_tx;
  logic                o_tx_start;
  logic                i_tx_start_clear;
  logic                i_tx_busy;
  logic [1:0]          o_grant;
  logic                o_pkt_done;
  logic                o_pkt_id;
  logic [15:0]         o_pkt_len;
  logic                o_err_start_to;
  logic                o_err_lock_to;
  logic                i_err_clr;

  modport slave (
    input  i_req0_valid, i_req0_data, i_req0_last,
    input  i_req1_valid, i_req1_data, i_req1_last,
    input  i_tx_start_clear, i_tx_busy, i_err_clr,
    output o_req0_ready, o_req1_ready, o_tx, o_tx_start,
    output o_grant, o_pkt_done, o_pkt_id, o_pkt_len,
    output o_err_start_to, o_err_lock_to
  );

  modport master (
    output i_req0_valid, i_req0_data, i_req0_last,
    output i_req1_valid, i_req1_data, i_req1_last,
    output i_tx_start_clear, i_tx_busy, i_err_clr,
    input  o_req0_ready, o_req1_ready, o_tx, o_tx_start,
    input  o_grant, o_pkt_done, o_pkt_id, o_pkt_len,
    input  o_err_start_to, o_err_lock_to
  );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin, packet-locked scheduler of two byte requesters onto one UART TX
module uart_tx_sched #(
  parameter int START_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_sched_if.slave   bus
);

  localparam int SW = $clog2(START_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_START, S_WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_last_q, rr_last_d;
  logic [7:0]       tx_q, tx_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [SW-1:0]    start_cnt_q, start_cnt_d;
  logic             wait_cnt_q, wait_cnt_d;
  logic             tx_start_q, tx_start_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_id_q, pkt_id_d;
  logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
  logic             err_start_q, err_start_d;
  logic             err_lock_q, err_lock_d;
  logic             set_start, set_lock;
  logic             owner;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             pick;

  assign owner     = grant_q[1];
  assign sel_valid = owner ? bus.i_req1_valid : bus.i_req0_valid;
  assign sel_data  = owner ? bus.i_req1_data  : bus.i_req0_data;
  assign sel_last  = owner ? bus.i_req1_last  : bus.i_req0_last;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    tx_d        = tx_q;
    last_d      = last_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    start_cnt_d = start_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    tx_start_d  = tx_start_q;
    pkt_done_d  = 1'b0;
    pkt_id_d    = pkt_id_q;
    pkt_len_d   = pkt_len_q;
    set_start   = 1'b0;
    set_lock    = 1'b0;
    pick        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req0_valid || bus.i_req1_valid) begin
          pick       = (bus.i_req0_valid && bus.i_req1_valid) ? ~rr_last_q : bus.i_req1_valid;
          grant_d    = pick ? 2'b10 : 2'b01;
          idle_cnt_d = '0;
          state_d    = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (sel_valid) begin
          tx_d        = sel_data;
          last_d      = sel_last;
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          start_cnt_d = '0;
          tx_start_d  = 1'b1;
          state_d     = S_START;
        end else if (idle_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
          set_lock   = 1'b1;
          pkt_id_d   = owner;
          grant_d    = 2'b00;
          rr_last_d  = owner;
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + LW'(1);
        end
      end
      S_START: begin
        // A clear arriving on the timeout cycle still counts as a delivered byte
        if (bus.i_tx_start_clear) begin
          tx_start_d = 1'b0;
          wait_cnt_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end else if (start_cnt_q == SW'(START_TIMEOUT - 1)) begin
          tx_start_d = 1'b0;
          set_start  = 1'b1;
          pkt_id_d   = owner;
          grant_d    = 2'b00;
          rr_last_d  = owner;
          byte_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end
      S_WAIT_DONE: begin
        wait_cnt_d = 1'b1;
        if (wait_cnt_q && !bus.i_tx_busy) begin
          if (last_q) begin
            pkt_done_d = 1'b1;
            pkt_id_d   = owner;
            pkt_len_d  = byte_cnt_q;
            grant_d    = 2'b00;
            byte_cnt_d = '0;
            rr_last_d  = owner;
            state_d    = S_IDLE;
          end else begin
            idle_cnt_d = '0;
            state_d    = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_start_d = set_start | (err_start_q & ~bus.i_err_clr);
    err_lock_d  = set_lock  | (err_lock_q  & ~bus.i_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      rr_last_q   <= 1'b1;
      tx_q        <= '0;
      last_q      <= 1'b0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      start_cnt_q <= '0;
      wait_cnt_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_id_q    <= 1'b0;
      pkt_len_q   <= '0;
      err_start_q <= 1'b0;
      err_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      tx_q        <= tx_d;
      last_q      <= last_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      start_cnt_q <= start_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      tx_start_q  <= tx_start_d;
      pkt_done_q  <= pkt_done_d;
      pkt_id_q    <= pkt_id_d;
      pkt_len_q   <= pkt_len_d;
      err_start_q <= err_start_d;
      err_lock_q  <= err_lock_d;
    end
  end

  assign bus.o_req0_ready   = (state_q == S_ACCEPT) && grant_q[0];
  assign bus.o_req1_ready   = (state_q == S_ACCEPT) && grant_q[1];
  assign bus.o_tx           = tx_q;
  assign bus.o_tx_start     = tx_start_q;
  assign bus.o_grant        = grant_q;
  assign bus.o_pkt_done     = pkt_done_q;
  assign bus.o_pkt_id       = pkt_id_q;
  assign bus.o_pkt_len      = 16'(pkt_len_q);
  assign bus.o_err_start_to = err_start_q;
  assign bus.o_err_lock_to  = err_lock_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench for uart_tx_sched with queue-driven requesters and a UART model
module tb_uart_tx_sched;
  localparam int ST = 16;
  localparam int LT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.START_TIMEOUT(ST), .LOCK_TIMEOUT(LT), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit pop0, pop1;

  bit uart_dead = 1'b0;
  int clr_delay = 3;
  int busy_len = 20;
  int ucnt = 0;
  int busy_left = 0;
  bit clr_sent = 1'b0;
  logic [7:0] tx_log[$];

  int pd_id[$];
  int pd_len[$];
  logic [1:0] grant_or = 2'b00;
  bit rdy0_seen = 1'b0;
  logic [7:0] exp2 [8];
  int k;
  int start_hi;

  // Byte is consumed at the posedge following a negedge where valid&ready held
  always @(negedge clk) begin
    if (pop0 && q0.size() > 0) void'(q0.pop_front());
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    bus.i_req0_valid = q0.size() > 0;
    bus.i_req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.i_req0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    bus.i_req1_valid = q1.size() > 0;
    bus.i_req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.i_req1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    pop0 = bus.i_req0_valid && bus.o_req0_ready;
    pop1 = bus.i_req1_valid && bus.o_req1_ready;
  end

  always @(negedge clk) begin
    bus.i_tx_start_clear = 1'b0;
    if (busy_left > 0) busy_left--;
    if (!bus.o_tx_start) begin
      ucnt = 0;
      clr_sent = 1'b0;
    end else if (!uart_dead && !clr_sent) begin
      ucnt++;
      if (ucnt == clr_delay) begin
        bus.i_tx_start_clear = 1'b1;
        clr_sent = 1'b1;
        busy_left = busy_len;
        tx_log.push_back(bus.o_tx);
      end
    end
    bus.i_tx_busy = busy_left > 0;
  end

  always @(negedge clk) begin
    if (bus.o_pkt_done) begin
      pd_id.push_back(int'(bus.o_pkt_id));
      pd_len.push_back(int'(bus.o_pkt_len));
    end
    grant_or = grant_or | bus.o_grant;
    if (bus.o_req0_ready) rdy0_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pkts(input int n, input string tag);
    for (int i = 0; i < 3000 && pd_id.size() < n; i++) tick();
    check_eq(tag, pd_id.size(), n);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    pd_id.delete();
    pd_len.delete();
  endtask

  initial begin
    bus.i_req0_valid = 1'b0; bus.i_req0_data = 8'h00; bus.i_req0_last = 1'b0;
    bus.i_req1_valid = 1'b0; bus.i_req1_data = 8'h00; bus.i_req1_last = 1'b0;
    bus.i_tx_start_clear = 1'b0; bus.i_tx_busy = 1'b0; bus.i_err_clr = 1'b0;

    repeat (3) tick();
    check_eq("rst_grant", bus.o_grant, 2'b00);
    check_eq("rst_tx_start", bus.o_tx_start, 1'b0);
    check_eq("rst_tx", bus.o_tx, 8'h00);
    check_eq("rst_ready", {bus.o_req1_ready, bus.o_req0_ready}, 2'b00);
    check_eq("rst_done", bus.o_pkt_done, 1'b0);
    check_eq("rst_errs", {bus.o_err_lock_to, bus.o_err_start_to}, 2'b00);
    rst_n = 1'b1;
    tick();

    // single packet, no contention
    grant_or = 2'b00;
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
    wait_pkts(1, "t1_wait");
    check_eq("t1_ntx", tx_log.size(), 3);
    check_eq("t1_tx0", tx_log[0], 8'h41);
    check_eq("t1_tx1", tx_log[1], 8'h42);
    check_eq("t1_tx2", tx_log[2], 8'h43);
    check_eq("t1_id", pd_id[0], 0);
    check_eq("t1_len", pd_len[0], 3);
    check_eq("t1_grant_or", grant_or, 2'b01);

    // contention from reset: round-robin by packet
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    clear_logs();
    busy_len = 3;
    q0.push_back(9'h0A0); q0.push_back(9'h1A1); q0.push_back(9'h0A2); q0.push_back(9'h1A3);
    q1.push_back(9'h0B0); q1.push_back(9'h1B1); q1.push_back(9'h0B2); q1.push_back(9'h1B3);
    wait_pkts(4, "t2_wait");
    exp2 = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
    for (int i = 0; i < 8; i++) check_eq($sformatf("t2_tx%0d", i), tx_log[i], exp2[i]);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_id%0d", i), pd_id[i], i % 2);
      check_eq($sformatf("t2_len%0d", i), pd_len[i], 2);
    end

    // lock hold: req1 keeps TX while req0 waits
    clear_logs();
    q1.push_back(9'h0C0); q1.push_back(9'h0C1); q1.push_back(9'h0C2); q1.push_back(9'h1C3);
    for (int i = 0; i < 50 && bus.o_grant != 2'b10; i++) tick();
    check_eq("t3_grant1", bus.o_grant, 2'b10);
    rdy0_seen = 1'b0;
    q0.push_back(9'h1D0);
    for (int i = 0; i < 3000 && pd_id.size() < 1; i++) tick();
    check_eq("t3_rdy0_early", rdy0_seen, 1'b0);
    check_eq("t3_done", bus.o_pkt_done, 1'b1);
    check_eq("t3_grant_idle", bus.o_grant, 2'b00);
    check_eq("t3_id", pd_id[0], 1);
    check_eq("t3_len", pd_len[0], 4);
    tick();
    check_eq("t3_grant0", bus.o_grant, 2'b01);
    wait_pkts(2, "t3_wait");
    check_eq("t3_id2", pd_id[1], 0);

    // START timeout
    clear_logs();
    uart_dead = 1'b1;
    start_hi = 0;
    q0.push_back(9'h1E0);
    for (int i = 0; i < 500 && !bus.o_err_start_to; i++) begin
      tick();
      if (bus.o_tx_start) start_hi++;
    end
    check_eq("t4_err", bus.o_err_start_to, 1'b1);
    check_eq("t4_start_cycles", start_hi, ST);
    check_eq("t4_tx_start", bus.o_tx_start, 1'b0);
    check_eq("t4_grant", bus.o_grant, 2'b00);
    check_eq("t4_pkt_id", bus.o_pkt_id, 1'b0);
    check_eq("t4_no_done", pd_id.size(), 0);
    uart_dead = 1'b0;
    q1.push_back(9'h1E1);
    wait_pkts(1, "t4_wait");
    check_eq("t4_next_id", pd_id[0], 1);

    // lock timeout, then clear racing a second timeout
    bus.i_err_clr = 1'b1; tick(); bus.i_err_clr = 1'b0;
    check_eq("t5_cleared", {bus.o_err_lock_to, bus.o_err_start_to}, 2'b00);
    clear_logs();
    q0.push_back(9'h055);
    k = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.o_err_lock_to) break;
      if (bus.o_req0_ready && !bus.i_req0_valid) k++;
      else k = 0;
    end
    check_eq("t5_err", bus.o_err_lock_to, 1'b1);
    check_eq("t5_lock_cycles", k, LT);
    check_eq("t5_pkt_id", bus.o_pkt_id, 1'b0);
    check_eq("t5_grant", bus.o_grant, 2'b00);
    bus.i_err_clr = 1'b1; tick(); bus.i_err_clr = 1'b0;
    check_eq("t5_clr1", bus.o_err_lock_to, 1'b0);
    q0.push_back(9'h056);
    k = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.o_req0_ready && !bus.i_req0_valid) k++;
      else k = 0;
      if (k == LT) begin
        bus.i_err_clr = 1'b1;
        break;
      end
    end
    check_eq("t5_race_reach", k, LT);
    tick();
    bus.i_err_clr = 1'b0;
    check_eq("t5_race", bus.o_err_lock_to, 1'b1);
    check_eq("t5_race_start", bus.o_err_start_to, 1'b0);
    tick();
    bus.i_err_clr = 1'b1; tick(); bus.i_err_clr = 1'b0;
    check_eq("t5_clr2", bus.o_err_lock_to, 1'b0);

    // async reset during WAIT_DONE
    clear_logs();
    busy_len = 20;
    q1.push_back(9'h0F0); q1.push_back(9'h1F1);
    for (int i = 0; i < 200 && tx_log.size() < 1; i++) tick();
    tick();
    check_eq("t6_pre_grant", bus.o_grant, 2'b10);
    check_eq("t6_pre_tx", bus.o_tx, 8'hF0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_grant", bus.o_grant, 2'b00);
    check_eq("t6_rst_tx", bus.o_tx, 8'h00);
    check_eq("t6_rst_start", bus.o_tx_start, 1'b0);
    check_eq("t6_rst_ready", bus.o_req1_ready, 1'b0);
    check_eq("t6_rst_done", bus.o_pkt_done, 1'b0);
    q1.delete();
    pop1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    q1.push_back(9'h1F2);
    wait_pkts(1, "t6_wait1");
    check_eq("t6_id1", pd_id[0], 1);
    check_eq("t6_len1", pd_len[0], 1);
    q0.push_back(9'h1F3);
    q1.push_back(9'h1F4);
    wait_pkts(3, "t6_wait3");
    check_eq("t6_tie_id", pd_id[1], 0);
    check_eq("t6_after_id", pd_id[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
